// File: rtl/csi2_lane2_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module   : csi2_lane2_pkt_parser
// Purpose  : MIPI CSI-2 packet decoder for a 2-lane merged byte stream that is
//            already sync-byte stripped and lane aligned. It checks the header
//            ECC, filters on virtual channel and data type, tracks frame valid
//            from FS/FE short packets and forwards RAW8 long-packet payload as
//            16-bit words qualified by line valid. The CRC word is discarded.
//
// Ports    : clk        - byte clock (lane word clock)
//            rstn       - asynchronous active-low reset (sync release upstream)
//            lane_data  - [7:0] lane0 byte, [15:8] lane1 byte, in byte order
//            lane_valid - high for one whole HS burst (one packet per burst)
//            dout       - payload word, same byte order as lane_data
//            fv_out     - frame valid
//            lv_out     - line valid / payload qualifier for dout
//            ecc_err    - 1-cycle pulse on header ECC mismatch
//            pkt_err    - 1-cycle pulse on truncation or illegal pixel WC
//
// Revision : 1.0 - initial release
// ============================================================================
module csi2_lane2_pkt_parser #(
    parameter logic [1:0]  VC       = 2'd0,
    parameter logic [5:0]  DT_PIXEL = 6'h2A,
    parameter logic [15:0] MAX_WC   = 16'd8192
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] lane_data,
    input  logic        lane_valid,
    output logic [15:0] dout,
    output logic        fv_out,
    output logic        lv_out,
    output logic        ecc_err,
    output logic        pkt_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_HDR1     = 3'd1;
    localparam logic [2:0] c_S_PAYLOAD  = 3'd2;
    localparam logic [2:0] c_S_CRC      = 3'd3;
    localparam logic [2:0] c_S_WAIT_END = 3'd4;

    localparam logic [5:0] c_DT_FS       = 6'h00;
    localparam logic [5:0] c_DT_FE       = 6'h01;
    localparam logic [5:0] c_DT_SHORT_HI = 6'h0F;

    // ------------------------------------------------------------------------
    // CSI-2 6-bit Hamming header ECC over d = {WC[15:0], DI[7:0]}
    // ------------------------------------------------------------------------
    function automatic logic [5:0] f_csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
               d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
               d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
               d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
               d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_di;        // data identifier from header word0
    logic [7:0]  r_wc_lo;     // WC[7:0] from header word0
    logic [15:0] r_cnt;       // payload words still expected
    logic [15:0] r_dout;
    logic        r_fv;
    logic        r_lv;
    logic        r_ecc_err;
    logic        r_pkt_err;

    // ------------------------------------------------------------------------
    // Header decode. Only meaningful in HDR1, where lane_data carries word1.
    // ------------------------------------------------------------------------
    logic [15:0] w_wc;
    logic [7:0]  w_ecc_rx;
    logic [5:0]  w_ecc_calc;
    logic [5:0]  w_dt;
    logic        w_ecc_ok;
    logic        w_vc_ok;
    logic        w_is_pixel;
    logic        w_wc_ok;
    logic        w_line_ok;

    assign w_wc       = {lane_data[7:0], r_wc_lo};
    assign w_ecc_rx   = lane_data[15:8];
    assign w_ecc_calc = f_csi2_ecc({w_wc, r_di});
    // Reserved ECC bits must be zero; no single-bit correction is attempted.
    assign w_ecc_ok   = (w_ecc_rx[7:6] == 2'b00) && (w_ecc_rx[5:0] == w_ecc_calc);
    assign w_vc_ok    = (r_di[7:6] == VC);
    assign w_dt       = r_di[5:0];
    assign w_is_pixel = (w_dt == DT_PIXEL);
    // Two RAW8 bytes per word, so a pixel line needs an even, non-zero WC.
    assign w_wc_ok    = !w_wc[0] && (w_wc != 16'd0) && (w_wc <= MAX_WC);
    assign w_line_ok  = w_ecc_ok && w_vc_ok && w_is_pixel && w_wc_ok;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (lane_valid) w_state_nxt = c_S_HDR1;
            end
            c_S_HDR1: begin
                if (!lane_valid)    w_state_nxt = c_S_IDLE;
                else if (w_line_ok) w_state_nxt = c_S_PAYLOAD;
                else                w_state_nxt = c_S_WAIT_END;
            end
            c_S_PAYLOAD: begin
                if (!lane_valid)           w_state_nxt = c_S_IDLE;
                else if (r_cnt == 16'd1)   w_state_nxt = c_S_CRC;
            end
            c_S_CRC: begin
                // A burst that ends right after the last payload word is fine.
                w_state_nxt = lane_valid ? c_S_WAIT_END : c_S_IDLE;
            end
            c_S_WAIT_END: begin
                if (!lane_valid) w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / datapath next values (all outputs are registered below)
    // ------------------------------------------------------------------------
    logic        w_hdr_load;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_dout_nxt;
    logic        w_fv_nxt;
    logic        w_lv_nxt;
    logic        w_ecc_err_nxt;
    logic        w_pkt_err_nxt;

    always_comb begin
        w_hdr_load    = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_dout_nxt    = r_dout;       // dout holds while lv_out is low
        w_fv_nxt      = r_fv;
        w_lv_nxt      = 1'b0;
        w_ecc_err_nxt = 1'b0;
        w_pkt_err_nxt = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_hdr_load = lane_valid;
            end
            c_S_HDR1: begin
                if (!lane_valid) begin
                    w_pkt_err_nxt = 1'b1;
                end else if (!w_ecc_ok) begin
                    w_ecc_err_nxt = 1'b1;
                end else if (w_vc_ok) begin
                    if (w_dt == c_DT_FS) begin
                        w_fv_nxt = 1'b1;
                    end else if (w_dt == c_DT_FE) begin
                        w_fv_nxt = 1'b0;
                    end else if (w_dt <= c_DT_SHORT_HI) begin
                        w_fv_nxt = r_fv;   // other short packets are ignored
                    end else if (w_is_pixel) begin
                        if (w_wc_ok) w_cnt_nxt = {1'b0, w_wc[15:1]};
                        else         w_pkt_err_nxt = 1'b1;
                    end
                end
            end
            c_S_PAYLOAD: begin
                if (lane_valid) begin
                    w_dout_nxt = lane_data;
                    w_lv_nxt   = 1'b1;
                    w_cnt_nxt  = r_cnt - 16'd1;
                end else begin
                    w_pkt_err_nxt = 1'b1;
                end
            end
            default: begin
                w_lv_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_di      <= 8'd0;
            r_wc_lo   <= 8'd0;
            r_cnt     <= 16'd0;
            r_dout    <= 16'd0;
            r_fv      <= 1'b0;
            r_lv      <= 1'b0;
            r_ecc_err <= 1'b0;
            r_pkt_err <= 1'b0;
        end else begin
            if (w_hdr_load) begin
                r_di    <= lane_data[7:0];
                r_wc_lo <= lane_data[15:8];
            end
            r_cnt     <= w_cnt_nxt;
            r_dout    <= w_dout_nxt;
            r_fv      <= w_fv_nxt;
            r_lv      <= w_lv_nxt;
            r_ecc_err <= w_ecc_err_nxt;
            r_pkt_err <= w_pkt_err_nxt;
        end
    end

    assign dout    = r_dout;
    assign fv_out  = r_fv;
    assign lv_out  = r_lv;
    assign ecc_err = r_ecc_err;
    assign pkt_err = r_pkt_err;

endmodule
`default_nettype wire

// File: tb/tb_csi2_lane2_pkt_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_csi2_lane2_pkt_parser
// Purpose  : Self-checking bench for csi2_lane2_pkt_parser. Bursts are built as
//            word lists; a packet-level reference model derives the expected
//            per-cycle lv/dout/fv/ecc_err/pkt_err trace for each burst.
// Revision : 1.0 - initial release
// ============================================================================

// Compares the captured trace against the model trace for one burst.
`define CHECK_TRACE(NAME) \
    for (int t = 0; t < n_cyc; t++) begin \
        checks++; if (a_lv[t] !== e_lv[t]) begin failures++; $display("FAIL %s t=%0d lv_out got=%b exp=%b", NAME, t, a_lv[t], e_lv[t]); end \
        checks++; if (a_fv[t] !== e_fv[t]) begin failures++; $display("FAIL %s t=%0d fv_out got=%b exp=%b", NAME, t, a_fv[t], e_fv[t]); end \
        checks++; if (a_ecc[t] !== e_ecc[t]) begin failures++; $display("FAIL %s t=%0d ecc_err got=%b exp=%b", NAME, t, a_ecc[t], e_ecc[t]); end \
        checks++; if (a_pkt[t] !== e_pkt[t]) begin failures++; $display("FAIL %s t=%0d pkt_err got=%b exp=%b", NAME, t, a_pkt[t], e_pkt[t]); end \
        if (e_lv[t]) begin checks++; if (a_dout[t] !== e_dout[t]) begin failures++; $display("FAIL %s t=%0d dout got=%h exp=%h", NAME, t, a_dout[t], e_dout[t]); end end \
    end

module tb_csi2_lane2_pkt_parser;

    localparam int          c_MAXT = 64;
    localparam logic [1:0]  c_VC   = 2'd0;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] lane_data;
    logic        lane_valid;
    logic [15:0] dout;
    logic        fv_out;
    logic        lv_out;
    logic        ecc_err;
    logic        pkt_err;

    always #5 clk = ~clk;

    csi2_lane2_pkt_parser #(
        .VC       (2'd0),
        .DT_PIXEL (6'h2A),
        .MAX_WC   (16'd8192)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .dout       (dout),
        .fv_out     (fv_out),
        .lv_out     (lv_out),
        .ecc_err    (ecc_err),
        .pkt_err    (pkt_err)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] burst[$];
    logic        m_fv;          // model frame-valid state
    int          n_cyc;

    logic        e_lv [c_MAXT];
    logic        e_fv [c_MAXT];
    logic        e_ecc[c_MAXT];
    logic        e_pkt[c_MAXT];
    logic [15:0] e_dout[c_MAXT];
    logic        a_lv [c_MAXT];
    logic        a_fv [c_MAXT];
    logic        a_ecc[c_MAXT];
    logic        a_pkt[c_MAXT];
    logic [15:0] a_dout[c_MAXT];

    // Syndrome column of each header data bit (bit i of {WC,DI}).
    logic [5:0] ecc_col [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    function automatic logic [5:0] ecc_ref(input logic [23:0] d);
        logic [5:0] e = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ecc_col[i];
        return e;
    endfunction

    task automatic push_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] flip);
        logic [7:0] ecc;
        ecc = {2'b00, ecc_ref({wc, di})} ^ flip;
        burst.push_back({wc[7:0], di});
        burst.push_back({ecc, wc[15:8]});
    endtask

    // Packet-level model: expected trace for the current burst plus gap idles.
    task automatic build_expect(input int gap);
        int L, n, avail;
        logic [15:0] w0, w1;
        logic [7:0]  di, ecc;
        logic [15:0] wc;
        logic [5:0]  dt;
        L = burst.size();
        n_cyc = L + gap;
        for (int t = 0; t < c_MAXT; t++) begin
            e_lv[t] = 1'b0; e_ecc[t] = 1'b0; e_pkt[t] = 1'b0;
            e_dout[t] = 16'd0; e_fv[t] = m_fv;
        end
        if (L == 1) begin
            e_pkt[1] = 1'b1;
        end else begin
            w0 = burst[0]; w1 = burst[1];
            di = w0[7:0]; wc = {w1[7:0], w0[15:8]}; ecc = w1[15:8];
            dt = di[5:0];
            if (ecc != {2'b00, ecc_ref({wc, di})}) begin
                e_ecc[1] = 1'b1;
            end else if (di[7:6] == c_VC) begin
                if (dt == 6'h00 || dt == 6'h01) begin
                    m_fv = (dt == 6'h00);
                    for (int t = 1; t < c_MAXT; t++) e_fv[t] = m_fv;
                end else if (dt == 6'h2A) begin
                    if (wc % 2 == 1 || wc == 0 || wc > 8192) begin
                        e_pkt[1] = 1'b1;
                    end else begin
                        n = wc / 2;
                        avail = L - 2;
                        for (int p = 0; p < n && p < avail; p++) begin
                            e_lv[2 + p]   = 1'b1;
                            e_dout[2 + p] = burst[2 + p];
                        end
                        if (avail < n) e_pkt[L] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Drives the burst then gap idle cycles, capturing outputs #1 after each edge.
    task automatic drive_burst(input int gap);
        int L;
        L = burst.size();
        for (int t = 0; t < L + gap; t++) begin
            lane_valid = (t < L);
            lane_data  = (t < L) ? burst[t] : 16'($urandom);
            @(posedge clk);
            #1;
            a_lv[t] = lv_out; a_fv[t] = fv_out; a_ecc[t] = ecc_err;
            a_pkt[t] = pkt_err; a_dout[t] = dout;
        end
        lane_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; lane_valid = 1'b0; lane_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({fv_out, lv_out, ecc_err, pkt_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {fv_out, lv_out, ecc_err, pkt_err}); end
        checks++; if (dout !== 16'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({fv_out, lv_out, ecc_err, pkt_err} !== 4'b0) begin failures++; $display("FAIL post_reset_flags got=%b exp=0000", {fv_out, lv_out, ecc_err, pkt_err}); end
        m_fv = 1'b0;
    endtask

    task automatic test_frame_start();
        burst.delete();
        push_hdr(8'h00, 16'd0, 8'h00);
        build_expect(2); drive_burst(2);
        `CHECK_TRACE("frame_start")
    endtask

    task automatic test_raw8_line();
        burst.delete();
        push_hdr(8'h2A, 16'd4, 8'h00);
        burst.push_back(16'h2211); burst.push_back(16'h4433); burst.push_back(16'hBEEF);
        build_expect(2); drive_burst(2);
        `CHECK_TRACE("raw8_line")
    endtask

    task automatic test_ecc_error();
        burst.delete();
        push_hdr(8'h2A, 16'd4, 8'h01);
        burst.push_back(16'h2211); burst.push_back(16'h4433); burst.push_back(16'hBEEF);
        build_expect(1); drive_burst(1);
        `CHECK_TRACE("ecc_error")
        burst.delete();
        push_hdr(8'h2A, 16'd4, 8'h00);
        burst.push_back(16'h6655); burst.push_back(16'h8877); burst.push_back(16'h1234);
        build_expect(2); drive_burst(2);
        `CHECK_TRACE("ecc_recover")
    endtask

    task automatic test_truncated();
        burst.delete();
        push_hdr(8'h2A, 16'd6, 8'h00);
        burst.push_back(16'hA5A5);
        build_expect(2); drive_burst(2);
        `CHECK_TRACE("truncated")
        burst.delete();
        push_hdr(8'h01, 16'd0, 8'h00);
        build_expect(2); drive_burst(2);
        `CHECK_TRACE("frame_end")
    endtask

    task automatic test_filtering();
        burst.delete();
        push_hdr(8'h2B, 16'd10, 8'h00);
        for (int i = 0; i < 6; i++) burst.push_back(16'($urandom));
        build_expect(1); drive_burst(1);
        `CHECK_TRACE("filter_raw10")
        burst.delete();
        push_hdr(8'h6A, 16'd4, 8'h00);
        for (int i = 0; i < 3; i++) burst.push_back(16'($urandom));
        build_expect(1); drive_burst(1);
        `CHECK_TRACE("filter_vc1")
        burst.delete();
        push_hdr(8'h2A, 16'd5, 8'h00);
        for (int i = 0; i < 4; i++) burst.push_back(16'($urandom));
        build_expect(2); drive_burst(2);
        `CHECK_TRACE("filter_odd_wc")
    endtask

    task automatic test_async_reset();
        burst.delete();
        push_hdr(8'h00, 16'd7, 8'h00);
        build_expect(1); drive_burst(1);
        `CHECK_TRACE("ar_fs")
        burst.delete();
        push_hdr(8'h2A, 16'd16, 8'h00);
        for (int i = 0; i < 3; i++) burst.push_back(16'($urandom));
        for (int t = 0; t < 5; t++) begin
            lane_valid = 1'b1; lane_data = burst[t];
            @(posedge clk);
            #1;
        end
        #2;
        checks++; if ({fv_out, lv_out} !== 2'b11) begin failures++; $display("FAIL ar_pre fv,lv got=%b exp=11", {fv_out, lv_out}); end
        rstn = 1'b0;
        #1;
        checks++; if ({fv_out, lv_out, ecc_err, pkt_err} !== 4'b0) begin failures++; $display("FAIL ar_flags got=%b exp=0000", {fv_out, lv_out, ecc_err, pkt_err}); end
        checks++; if (dout !== 16'd0) begin failures++; $display("FAIL ar_dout got=%h exp=0000", dout); end
        lane_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        m_fv = 1'b0;
        burst.delete();
        push_hdr(8'h00, 16'd1, 8'h00);
        build_expect(1); drive_burst(1);
        `CHECK_TRACE("ar_fresh_fs")
        burst.delete();
        push_hdr(8'h2A, 16'd6, 8'h00);
        for (int i = 0; i < 4; i++) burst.push_back(16'($urandom));
        build_expect(2); drive_burst(2);
        `CHECK_TRACE("ar_fresh_line")
    endtask

    task automatic test_random();
        int k, n, L;
        logic [15:0] wc;
        for (int b = 0; b < 60; b++) begin
            burst.delete();
            k = $urandom_range(0, 9);
            L = 2 + $urandom_range(0, 12);
            case (k)
                0: push_hdr({c_VC, 6'h00}, 16'($urandom), 8'h00);
                1: push_hdr({c_VC, 6'h01}, 16'($urandom), 8'h00);
                2, 3, 4: begin
                    n = $urandom_range(1, 8);
                    push_hdr({c_VC, 6'h2A}, 16'(2 * n), 8'h00);
                    if ($urandom_range(0, 3) == 0) L = 2 + $urandom_range(0, n - 1);
                    else                           L = 2 + n + $urandom_range(0, 2);
                end
                5: push_hdr(8'($urandom), 16'($urandom_range(0, 40)), 8'(1 << $urandom_range(0, 7)));
                6: push_hdr({2'($urandom_range(1, 3)), 6'h2A}, 16'd4, 8'h00);
                7: push_hdr({c_VC, 6'($urandom)}, 16'($urandom_range(0, 20)), 8'h00);
                8: begin
                    case ($urandom_range(0, 2))
                        0:       wc = 16'(2 * $urandom_range(0, 10) + 1);
                        1:       wc = 16'd0;
                        default: wc = 16'(8193 + $urandom_range(0, 100));
                    endcase
                    push_hdr({c_VC, 6'h2A}, wc, 8'h00);
                end
                default: begin
                    burst.push_back(16'($urandom));
                    L = 1;
                end
            endcase
            while (burst.size() < L) burst.push_back(16'($urandom));
            n = $urandom_range(1, 3);
            build_expect(n); drive_burst(n);
            `CHECK_TRACE("random")
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_start();
        test_raw8_line();
        test_ecc_error();
        test_truncated();
        test_filtering();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`undef CHECK_TRACE
`default_nettype wire

// File: doc/csi2_lane2_pkt_parser.md
Name: csi2_lane2_pkt_parser

Overview:
- Decodes MIPI CSI-2 packets from the 2-lane merged byte stream, already sync-byte stripped and lane-aligned.
- Produces the 16-bit RAW8 payload stream with frame valid (fv) and line valid (lv) in the byte-clock domain.
- Sits directly upstream of the RAW8 2-lane FIFO/pixel-clock stage, which consumes dout/fv_out/lv_out as its din/fv_sclk/lv_sclk.
- Checks header ECC, filters virtual channel and data type, and discards CRC.

Parameters:
VC, 2'd0, virtual channel accepted (DI[7:6]).
DT_PIXEL, 6'h2A, long-packet data type forwarded as pixels (RAW8).
MAX_WC, 16'd8192, largest legal word count; larger WC is an error.

Ports:
clk  input  1  byte clock (lane word clock).
rstn  input  1  asynchronous active-low reset.
lane_data  input  16  [7:0]=lane0 byte, [15:8]=lane1 byte, in byte order.
lane_valid  input  1  high for the whole HS burst, first word = first header word; exactly one packet per burst.
dout  output  16  payload word, same byte order as lane_data.
fv_out  output  1  frame valid.
lv_out  output  1  line valid / payload qualifier for dout.
ecc_err  output  1  1-cycle pulse: header ECC mismatch.
pkt_err  output  1  1-cycle pulse: truncated packet, odd WC on DT_PIXEL, or WC>MAX_WC.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FSM in IDLE.
  - Reset mid-frame drops fv_out/lv_out immediately.
- Header word order:
  - Word0 = {WC[7:0], DI}.
  - Word1 = {ECC, WC[15:8]}.
- FSM states:
  - IDLE: on lane_valid=1, latch word0 -> HDR1.
  - HDR1:
    - lane_valid=0 -> pkt_err, go to IDLE.
    - Otherwise latch word1 and evaluate:
      - ECC check: compute 6-bit CSI-2 Hamming ECC over {WC[15:0],DI[7:0]}. Mismatch with ECC[5:0], or ECC[7:6]!=0 -> ecc_err, go to WAIT_END. No correction.
      - DI[7:6]!=VC -> go to WAIT_END silently.
      - DT=0x00 (Frame Start): fv_out<=1 next cycle, go to WAIT_END.
      - DT=0x01 (Frame End): fv_out<=0 next cycle, go to WAIT_END.
      - Other DT 0x02..0x0F (short packets): ignored, go to WAIT_END.
      - DT=DT_PIXEL with WC even, 0<WC<=MAX_WC: load word counter = WC/2, go to PAYLOAD.
      - DT=DT_PIXEL with WC odd, WC=0 or >MAX_WC: pkt_err, go to WAIT_END.
      - Any other long DT: go to WAIT_END (payload skipped, lv_out stays 0).
  - PAYLOAD:
    - Each cycle with lane_valid=1: dout<=lane_data, lv_out<=1, counter decrements.
    - Counter reaching 0 -> CRC.
    - lane_valid=0 before last word: lv_out<=0, pkt_err, go to IDLE.
  - CRC: consume one word (CRC unchecked), lv_out=0 -> WAIT_END. lane_valid=0 here is not an error -> IDLE.
  - WAIT_END: stay until lane_valid=0, then IDLE. Trailer/filler words ignored.
- Latency:
  - dout/lv_out are registered: 1 clk after the corresponding lane_data word.
  - lv_out is high for exactly WC/2 consecutive cycles per accepted line.
  - fv_out changes 1 clk after the FS/FE header word1 cycle.
- dout holds its last value when lv_out=0; downstream qualifies on lv_out only.
- fv_out is not forced by LS/LE packets. FS while fv_out=1 keeps it 1; FE while fv_out=0 keeps it 0.
- Lines outside FS/FE are still forwarded (lv_out independent of fv_out).
- Every error pulse lasts exactly one cycle and never alters fv_out.

Test Plan:
1. FS VC0: words 0x0000, 0x0000 (DI=0x00, WC=0, ECC=0x00) -> fv_out=1 from cycle 2 after burst start; ecc_err/pkt_err stay 0.
2. RAW8 line: DI=0x2A, WC=4, correct ECC, payload words 0x2211, 0x4433, CRC word 0xBEEF -> dout=0x2211 then 0x4433, lv_out high exactly 2 cycles (1-clk lag); CRC word never appears with lv_out=1.
3. Same header with ECC bit0 flipped -> one-cycle ecc_err, lv_out stays 0, fv_out unchanged, next valid burst parsed normally.
4. RAW8 WC=6 with lane_valid dropped after first payload word -> lv_out high 1 cycle, pkt_err pulse, FSM in IDLE; following FE (DI=0x01, correct ECC) -> fv_out=0.
5. Filtering: DI=0x2B (RAW10, WC=10), DI=0x6A (VC1 RAW8), DI=0x2A with WC=5 -> lv_out stays 0 throughout; pkt_err only for the WC=5 case.
6. Async rstn low mid-payload (lv_out=1, fv_out=1) -> all outputs 0 immediately; after release, a fresh FS + line sequence works.
